capture_ctrl: RTL and testbench

- Acquisition front end of the internal logic analyzer. It sits directly upstream of the circular-buffer readout stage.
- Samples the probe bus into an external circular sample memory through a write port.
- Holds a programmable pre-trigger history and detects a masked trigger pattern, then captures a fixed number of post-trigger samples.
- Then parks the write pointer on the oldest sample and issues read_enable beats, so the readout stage can stream the buffer oldest-first.

---
 rtl/capture_ctrl.sv | 134 +++++++++++++
 tb/tb_capture_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// Logic-analyzer acquisition front end: fills a circular sample buffer with pre-trigger
// history, waits for a masked trigger, captures post-trigger samples, then paces readout.
module capture_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEMORY_SIZE = 16,
    parameter int POST_TRIG   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic                  rd_ready,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  read_enable,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  triggered,
    output logic                  busy,
    output logic                  done
);
    localparam int PRE_LEN = MEMORY_SIZE - POST_TRIG;
    localparam int CW      = ADDR_WIDTH + 1;

    // Terminal counts: the count value seen during the final write/beat of each phase.
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_TRIG - 1);
    localparam logic [CW-1:0] BEAT_LAST = CW'(MEMORY_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        READOUT = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [CW-1:0]         pre_cnt, post_cnt, beat_cnt;
    logic                  match, start, trig_hit, finish;

    assign match = ((i_data ^ trig_value) & trig_mask) == '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        start    = 1'b0;
        trig_hit = 1'b0;
        finish   = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (arm) begin
                        start = 1'b1;
                        if (PRE_LEN == 0) state_n = ARMED;
                        else              state_n = PRE;
                    end
                end
                // Compare is deliberately not looked at here, even on the last PRE write.
                PRE: begin
                    if (pre_cnt == PRE_LAST) state_n = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        trig_hit = 1'b1;
                        if (POST_TRIG == 1) state_n = READOUT;
                        else                state_n = POST;
                    end
                end
                POST: begin
                    if (post_cnt == POST_LAST) state_n = READOUT;
                end
                READOUT: begin
                    if (rd_ready && beat_cnt == BEAT_LAST) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign mem_we      = (state == PRE) || (state == ARMED) || (state == POST);
    assign mem_wdata   = i_data;
    assign waddr       = wptr;
    assign read_enable = (state == READOUT) && rd_ready;
    assign busy        = (state != IDLE);

    // wptr wraps naturally; after the last write it sits on the oldest retained sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr      <= '0;
            pre_cnt   <= '0;
            post_cnt  <= '0;
            beat_cnt  <= '0;
            trig_addr <= '0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (start) begin
                wptr      <= '0;
                pre_cnt   <= '0;
                beat_cnt  <= '0;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else begin
                if (mem_we)         wptr     <= wptr + ADDR_WIDTH'(1);
                if (state == PRE)   pre_cnt  <= pre_cnt + CW'(1);
                if (read_enable)    beat_cnt <= beat_cnt + CW'(1);
            end
            if (trig_hit) begin
                trig_addr <= wptr;
                triggered <= 1'b1;
                post_cnt  <= CW'(1);
            end else if (state == POST) begin
                post_cnt  <= post_cnt + CW'(1);
            end
            if (finish) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: vector table of ramp captures, abort/reset corner sequences,
// and randomized captures checked against a trigger/buffer model computed from the sample stream.
module tb_capture_ctrl;
    localparam int DW = 8, AW = 4, MS = 16, PT = 8, PRE = MS - PT, NS = 300;

    logic          clk = 1'b0, reset = 1'b0, arm = 1'b0, abort = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] i_data = '0, trig_value = '0, trig_mask = '0;
    logic          mem_we, read_enable, triggered, busy, done;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] waddr, trig_addr;

    int errors = 0, checks = 0;
    int nw;
    logic [DW-1:0] tbmem [MS];
    logic [DW-1:0] drv   [NS];
    logic [7:0]    tv, tm;

    typedef struct {
        logic [7:0] tv, tm;
        int         exp_taddr, exp_waddr, exp_oldest;
    } vec_t;
    vec_t vecs [5];

    capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEMORY_SIZE(MS), .POST_TRIG(PT)) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort), .i_data(i_data),
        .trig_value(trig_value), .trig_mask(trig_mask), .rd_ready(rd_ready),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .waddr(waddr), .read_enable(read_enable),
        .trig_addr(trig_addr), .triggered(triggered), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // External sample memory as the readout stage would see it.
    always @(posedge clk) if (mem_we) tbmem[waddr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First sample index past the pre-trigger history whose masked bits match.
    function automatic int model_trig(input logic [7:0] v, input logic [7:0] m);
        for (int k = PRE; k < NS; k++)
            if (((drv[k] ^ v) & m) == 8'h00) return k;
        return -1;
    endfunction

    task automatic capture(input logic [7:0] v, input logic [7:0] m, input int stop_k,
                           input bit use_rst, input bit rnd_arm, output int n);
        bit ended = 1'b0;
        @(negedge clk);
        trig_value = v; trig_mask = m; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("arm_clears", {busy, done, triggered, waddr}, {1'b1, 1'b0, 1'b0, 4'd0});
        n = 0;
        for (int cyc = 0; cyc < NS && !ended; cyc++) begin
            if (!mem_we) begin
                ended = 1'b1;
            end else begin
                i_data = drv[n];
                arm = rnd_arm ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (n == stop_k && use_rst) begin
                    #1 reset = 1'b0;
                    #1 check("rst_async_clear",
                             {mem_we, read_enable, busy, done, triggered, waddr, trig_addr}, '0);
                    #1 reset = 1'b1;
                    ended = 1'b1;
                end else if (n == stop_k) begin
                    abort = 1'b1;
                    ended = 1'b1;
                end
                n++;
                @(negedge clk);
                abort = 1'b0;
            end
        end
        arm = 1'b0;
        if (!ended) check("capture_bound", 1, 0);
    endtask

    task automatic verify(input logic [7:0] v, input logic [7:0] m, input int n);
        int tk, total, bad;
        tk = model_trig(v, m);
        if (tk < 0) begin
            check("model_found_trigger", 0, 1);
            return;
        end
        total = tk + PT;
        check("write_count", n, total);
        check("triggered", triggered, 1);
        check("trig_addr", trig_addr, tk % MS);
        check("final_waddr", waddr, total % MS);
        check("we_low_busy", {mem_we, busy}, 2'b01);
        bad = 0;
        for (int j = 0; j < MS; j++)
            if (tbmem[(total - MS + j) % MS] !== drv[total - MS + j]) bad++;
        check("mem_contents", bad, 0);
    endtask

    task automatic readout(input bit rnd);
        int beats = 0, relerr = 0, extra = 0;
        for (int cyc = 0; cyc < 200 && beats < MS; cyc++) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
            #1;
            if (read_enable !== rd_ready) relerr++;
            if (rd_ready) beats++;
            @(negedge clk);
        end
        check("re_follows_ready", relerr, 0);
        check("beats", beats, MS);
        check("done_idle", {done, busy}, 2'b10);
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            #1;
            if (read_enable) extra++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        check("no_extra_beats", extra, 0);
        check("done_held", done, 1);
    endtask

    initial begin
        vecs[0] = '{8'h14, 8'hFF, 4, 12, 12};
        vecs[1] = '{8'h03, 8'h0F, 3, 11, 11};
        vecs[2] = '{8'h00, 8'h00, 8, 0, 0};
        vecs[3] = '{8'h07, 8'h07, 15, 7, 7};
        vecs[4] = '{8'h1F, 8'hFF, 15, 7, 23};

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            arm = 1'($urandom); abort = 1'($urandom); rd_ready = 1'($urandom);
            i_data = 8'($urandom); trig_value = 8'($urandom); trig_mask = 8'($urandom);
            #1 check("reset_hold", {mem_we, read_enable, busy, done, triggered, waddr, trig_addr}, '0);
        end
        @(negedge clk);
        arm = 1'b0; abort = 1'b0; rd_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, mem_we, done, waddr}, '0);

        // Ramp captures from the vector table.
        for (int k = 0; k < NS; k++) drv[k] = 8'(k);
        for (int i = 0; i < 5; i++) begin
            capture(vecs[i].tv, vecs[i].tm, -1, 1'b0, 1'b0, nw);
            verify(vecs[i].tv, vecs[i].tm, nw);
            check("tbl_trig_addr", trig_addr, vecs[i].exp_taddr);
            check("tbl_waddr", waddr, vecs[i].exp_waddr);
            check("tbl_oldest", tbmem[vecs[i].exp_waddr], vecs[i].exp_oldest);
            readout(1'b0);
        end

        // Abort while post_cnt == 3: sample 23 is the abort-cycle write.
        capture(8'h14, 8'hFF, 23, 1'b0, 1'b0, nw);
        check("abort_state", {busy, mem_we, done, triggered, trig_addr, waddr},
              {1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd8});
        rd_ready = 1'b1;
        #1 check("abort_no_beat", read_enable, 0);
        @(negedge clk);
        rd_ready = 1'b0;
        check("abort_stays_idle", {busy, done}, 2'b00);

        // Asynchronous reset at the same point.
        capture(8'h14, 8'hFF, 23, 1'b1, 1'b0, nw);
        check("idle_after_midrst", {busy, mem_we, waddr, triggered, done}, '0);

        // Randomized captures with arm pulses while busy.
        for (int r = 0; r < 6; r++) begin
            tv = 8'($urandom);
            tm = 8'($urandom) & 8'h25;
            for (int k = 0; k < NS; k++) drv[k] = 8'($urandom);
            drv[200] = tv;
            capture(tv, tm, -1, 1'b0, 1'b1, nw);
            verify(tv, tm, nw);
            readout(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
